xpb_table_gen: RTL

Sequential generator for the 2^DIGIT_BITS-entry XPB reduction tables consumed by the modular-square datapath. Given a modulus N and a base value B (B = 2^k mod N for the table's bit offset), it computes entry j = j·B mod N for j = 0 … 2^DIGIT_BITS−1 by repeated modular addition. It streams each entry to a table RAM over a write port with backpressure. It is the writer-side counterpart of the fixed combinational XPB lookup ROMs, so tables can be loaded at run time for any modulus.

---
 rtl/xpb_gen_pkg.sv | 20 ++
 rtl/xpb_mod_add.sv | 53 +++++
 rtl/xpb_table_gen.sv | 123 ++++++++++++
 3 files changed

// File: rtl/xpb_gen_pkg.sv
// Shared definitions for the XPB reduction-table generator.
//   DEF_WIDTH      : default modulus / base / entry width
//   DEF_DIGIT_BITS : default table index width
//   NUM_ENTRIES    : entries per table at the default index width
//   state_e        : generator sequencing states
package xpb_gen_pkg;

  localparam int unsigned DEF_WIDTH      = 1024;
  localparam int unsigned DEF_DIGIT_BITS = 5;
  localparam int unsigned NUM_ENTRIES    = 2 ** DEF_DIGIT_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_ADD,
    ST_SUB,
    ST_DONE
  } state_e;

endpackage

// File: rtl/xpb_mod_add.sv
// Two-stage modular accumulator: acc <- (acc + b) mod n.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : zero the accumulator and the partial sum
//   add_i      : stage 1, register sum = acc + b (WIDTH+1 bits)
//   sub_i      : stage 2, acc = (sum < n) ? sum : sum - n
//   b_i, n_i   : addend and modulus (caller keeps acc < n and b < n)
//   acc_o      : registered accumulator
module xpb_mod_add
  import xpb_gen_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             add_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] n_i,
  output logic [WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   sum_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  // Two extra bits so the sign of (sum - n) is an explicit borrow flag.
  always_comb begin
    diff   = {1'b0, sum_q} - {2'b00, n_i};
    borrow = diff[WIDTH+1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      acc_q <= '0;
    end else if (clr_i) begin
      sum_q <= '0;
      acc_q <= '0;
    end else begin
      if (add_i) begin
        sum_q <= {1'b0, acc_q} + {1'b0, b_i};
      end
      if (sub_i) begin
        acc_q <= borrow ? sum_q[WIDTH-1:0] : diff[WIDTH-1:0];
      end
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/xpb_table_gen.sv
// Run-time generator for XPB reduction tables: streams entry j = j*B mod N
// for j = 0 .. 2^DIGIT_BITS-1 to a table RAM over a write port with
// backpressure.
//   clk, rst_n      : clock, async active-low reset
//   start           : begin a run (sampled only while idle)
//   modulus, base   : N and B, captured on an accepted start (B < N)
//   busy            : run in progress, through the done cycle
//   done            : one-cycle pulse after the last entry is accepted
//   wr_en           : entry valid on wr_addr / wr_data
//   wr_addr,wr_data : entry index and value
//   wr_ready        : sink accepts the entry when wr_en && wr_ready
module xpb_table_gen
  import xpb_gen_pkg::*;
#(
  parameter int unsigned DIGIT_BITS = DEF_DIGIT_BITS,
  parameter int unsigned WIDTH      = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      modulus,
  input  logic [WIDTH-1:0]      base,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_en,
  output logic [DIGIT_BITS-1:0] wr_addr,
  output logic [WIDTH-1:0]      wr_data,
  input  logic                  wr_ready
);

  state_e                state_q;
  logic [WIDTH-1:0]      n_q;
  logic [WIDTH-1:0]      b_q;
  logic [DIGIT_BITS-1:0] idx_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  wr_en_q;

  logic                  clr;
  logic                  add;
  logic                  sub;
  logic [WIDTH-1:0]      acc;

  always_comb begin
    clr = (state_q == ST_IDLE) && start;
    add = (state_q == ST_ADD);
    sub = (state_q == ST_SUB);
  end

  xpb_mod_add #(
    .WIDTH (WIDTH)
  ) u_mod_add (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr),
    .add_i (add),
    .sub_i (sub),
    .b_i   (b_q),
    .n_i   (n_q),
    .acc_o (acc)
  );

  // wr_en is raised on entry to WRITE so it is a clean register output;
  // done is raised on the final acceptance so it coincides with DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            n_q     <= modulus;
            b_q     <= base;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            wr_en_q <= 1'b1;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (wr_ready) begin
            wr_en_q <= 1'b0;
            if (idx_q == '1) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= ST_ADD;
            end
          end
        end
        ST_ADD: begin
          state_q <= ST_SUB;
        end
        ST_SUB: begin
          wr_en_q <= 1'b1;
          state_q <= ST_WRITE;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = idx_q;
  assign wr_data = acc;

endmodule
